soc_mem_subsys: RTL and testbench

//  Parametrised memory subsystem for the pipelined RISC-V SoC: one writable instruction ROM,
//  a RAM_BANKS-way banked data RAM and a byte-stream boot loader that fills the ROM while the

---
 rtl/soc_mem_subsys_pkg.sv | 20 ++
 rtl/soc_boot_loader.sv | 114 +++++++++++
 rtl/soc_mem_subsys.sv | 140 ++++++++++++++
 tb/tb_soc_mem_subsys.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_subsys_pkg.sv
// Shared types and defaults for the SoC memory subsystem: loader state
// encodings, default memory depths and a select-width helper.
package soc_mem_subsys_pkg;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_FLUSH = 2'd1,
    LD_RUN   = 2'd2
  } ld_state_t;

  localparam int DEF_ROM_WORDS = 4096;
  localparam int DEF_RAM_WORDS = 4096;
  localparam int DEF_RAM_BANKS = 2;

  // Width of a select field for n choices; never narrower than one bit.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_boot_loader.sv
// Boot loader: packs a little-endian byte stream into ROM words while
// holding the core, then flushes for one cycle and releases the core.
module soc_boot_loader
  import soc_mem_subsys_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         hold_req,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  input  logic [7:0]                   ld_data,
  input  logic                         ld_last,
  output logic                         hold,
  output logic                         ld_ready,
  output logic                         ld_ovf,
  output logic                         rom_we,
  output logic [$clog2(ROM_WORDS)-1:0] rom_waddr,
  output logic [DATA_W-1:0]            rom_wdata
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = sel_bits(LANES);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  // One extra bit so the pointer can sit at ROM_WORDS once the ROM is full.
  localparam int PTR_W  = ROM_AW + 1;

  ld_state_t         state_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              ovf_reg;
  logic              busy_reg;
  logic              ready_reg;

  logic              accept;
  logic              full;
  logic              word_done;
  logic [DATA_W-1:0] word_next;

  // A start request wins over a byte presented in the same cycle.
  always_comb begin
    accept    = ready_reg && ld_valid && !ld_start;
    full      = (ptr_reg == PTR_W'(ROM_WORDS));
    word_next = acc_reg | (DATA_W'(ld_data) << (8 * lane_reg));
    word_done = accept && (ld_last || (lane_reg == LANE_W'(LANES - 1)));
    rom_we    = word_done && !full;
    rom_waddr = ptr_reg[ROM_AW-1:0];
    rom_wdata = word_next;
  end

  // Loader FSM with byte packer, word pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= LD_LOAD;
      ptr_reg   <= '0;
      lane_reg  <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b1;
      ready_reg <= 1'b1;
    end else if (ld_start) begin
      // Restart from any state; the pending byte (if any) is dropped.
      state_reg <= LD_LOAD;
      ptr_reg   <= '0;
      lane_reg  <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b1;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        LD_LOAD: begin
          if (accept) begin
            if (full) ovf_reg <= 1'b1;
            if (word_done) begin
              acc_reg  <= '0;
              lane_reg <= '0;
              if (!full) ptr_reg <= ptr_reg + 1'b1;
            end else begin
              acc_reg  <= word_next;
              lane_reg <= lane_reg + 1'b1;
            end
            if (ld_last) begin
              state_reg <= LD_FLUSH;
              ready_reg <= 1'b0;
            end
          end
        end
        LD_FLUSH: begin
          state_reg <= LD_RUN;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
        LD_RUN: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
        default: begin
          state_reg <= LD_LOAD;
          busy_reg  <= 1'b1;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign hold     = busy_reg | hold_req;
  assign ld_ready = ready_reg;
  assign ld_ovf   = ovf_reg;

endmodule

// File: rtl/soc_mem_subsys.sv
// SoC memory subsystem: loader-written instruction ROM, banked data RAM and
// the core hold. Optional macro SOC_MEM_BYTE_WE_EN adds per-byte RAM write
// strobes (ram_w_strb_i); without it every RAM write is a full word.
module soc_mem_subsys
  import soc_mem_subsys_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ROM_WORDS = DEF_ROM_WORDS,
  parameter int RAM_WORDS = DEF_RAM_WORDS,
  parameter int RAM_BANKS = DEF_RAM_BANKS
) (
  input  logic                clk_100MHz,
  input  logic                arst_n,
  input  logic                hold_i,
  output logic                hold_o,
  input  logic [ADDR_W-1:0]   rom_r_addr_i,
  output logic [DATA_W-1:0]   rom_r_data_o,
  input  logic                ram_r_ena_i,
  input  logic [ADDR_W-1:0]   ram_r_addr_i,
  output logic [DATA_W-1:0]   ram_r_data_o,
  input  logic                ram_w_ena_i,
  input  logic [ADDR_W-1:0]   ram_w_addr_i,
  input  logic [DATA_W-1:0]   ram_w_data_i,
`ifdef SOC_MEM_BYTE_WE_EN
  input  logic [DATA_W/8-1:0] ram_w_strb_i,
`endif
  input  logic                ld_start_i,
  input  logic                ld_valid_i,
  input  logic [7:0]          ld_data_i,
  input  logic                ld_last_i,
  output logic                ld_ready_o,
  output logic                ld_ovf_o,
  output logic                ram_err_o
);

  localparam int LANES      = DATA_W / 8;
  localparam int ROM_AW     = $clog2(ROM_WORDS);
  localparam int BANK_SHIFT = $clog2(RAM_BANKS);
  localparam int BANK_W     = sel_bits(RAM_BANKS);
  localparam int BANK_DEPTH = RAM_WORDS / RAM_BANKS;
  localparam int ROW_W      = sel_bits(BANK_DEPTH);

  // ---------------- instruction ROM ----------------
  logic              rom_we;
  logic [ROM_AW-1:0] rom_waddr;
  logic [DATA_W-1:0] rom_wdata;
  logic [DATA_W-1:0] rom_mem [ROM_WORDS];
  logic [ADDR_W-3:0] rom_word;
  logic              rom_in;

  soc_boot_loader #(
    .DATA_W    (DATA_W),
    .ROM_WORDS (ROM_WORDS)
  ) u_loader (
    .clk       (clk_100MHz),
    .arst_n    (arst_n),
    .hold_req  (hold_i),
    .ld_start  (ld_start_i),
    .ld_valid  (ld_valid_i),
    .ld_data   (ld_data_i),
    .ld_last   (ld_last_i),
    .hold      (hold_o),
    .ld_ready  (ld_ready_o),
    .ld_ovf    (ld_ovf_o),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata)
  );

  // Only the loader writes the ROM.
  always_ff @(posedge clk_100MHz) begin
    if (rom_we) rom_mem[rom_waddr] <= rom_wdata;
  end

  assign rom_word     = rom_r_addr_i[ADDR_W-1:2];
  assign rom_in       = ({2'b00, rom_word} < ADDR_W'(ROM_WORDS));
  assign rom_r_data_o = rom_in ? rom_mem[ROM_AW'(rom_word)] : '0;

  // ---------------- banked data RAM ----------------
  logic [ADDR_W-3:0] r_word, w_word;
  logic              r_in, w_in, w_ok;
  logic [ROW_W-1:0]  r_row, w_row;
  logic [BANK_W-1:0] r_bank, w_bank;
  logic [LANES-1:0]  w_strb;
  logic [DATA_W-1:0] bank_rdata [RAM_BANKS];
  logic              ram_err_reg;

  assign r_word = ram_r_addr_i[ADDR_W-1:2];
  assign w_word = ram_w_addr_i[ADDR_W-1:2];
  assign r_in   = ({2'b00, r_word} < ADDR_W'(RAM_WORDS));
  assign w_in   = ({2'b00, w_word} < ADDR_W'(RAM_WORDS));
  assign w_ok   = ram_w_ena_i && w_in;
  assign r_row  = ROW_W'(r_word >> BANK_SHIFT);
  assign w_row  = ROW_W'(w_word >> BANK_SHIFT);

  if (RAM_BANKS > 1) begin : g_bank_sel
    assign r_bank = r_word[BANK_W-1:0];
    assign w_bank = w_word[BANK_W-1:0];
  end else begin : g_bank_one
    assign r_bank = '0;
    assign w_bank = '0;
  end

`ifdef SOC_MEM_BYTE_WE_EN
  assign w_strb = ram_w_strb_i;
`else
  assign w_strb = '1;
`endif

  for (genvar gi = 0; gi < RAM_BANKS; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];

    // Byte-lane write into this bank when the word address selects it.
    always_ff @(posedge clk_100MHz) begin
      if (w_ok && (w_bank == BANK_W'(gi))) begin
        for (int l = 0; l < LANES; l++) begin
          if (w_strb[l]) mem[w_row][8*l +: 8] <= ram_w_data_i[8*l +: 8];
        end
      end
    end

    assign bank_rdata[gi] = mem[r_row];
  end

  assign ram_r_data_o = (ram_r_ena_i && r_in) ? bank_rdata[r_bank] : '0;

  // Sticky flag for any enabled RAM access outside the populated range.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) ram_err_reg <= 1'b0;
    else if ((ram_r_ena_i && !r_in) || (ram_w_ena_i && !w_in)) ram_err_reg <= 1'b1;
  end

  assign ram_err_o = ram_err_reg;

  // Byte-offset bits are ignored by word-aligned accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rom_r_addr_i[1:0], ram_r_addr_i[1:0], ram_w_addr_i[1:0]};

endmodule

// File: tb/tb_soc_mem_subsys.sv
// Directed bench for soc_mem_subsys with a 4-word ROM and a 16-word,
// two-bank RAM. Define SOC_MEM_BYTE_WE_EN for both bench and RTL to
// exercise the byte-strobe writes.
module tb_soc_mem_subsys;

  logic        clk_100MHz = 1'b0;
  logic        arst_n     = 1'b0;
  logic        hold_i     = 1'b0;
  logic        hold_o;
  logic [31:0] rom_r_addr_i = '0;
  logic [31:0] rom_r_data_o;
  logic        ram_r_ena_i  = 1'b0;
  logic [31:0] ram_r_addr_i = '0;
  logic [31:0] ram_r_data_o;
  logic        ram_w_ena_i  = 1'b0;
  logic [31:0] ram_w_addr_i = '0;
  logic [31:0] ram_w_data_i = '0;
`ifdef SOC_MEM_BYTE_WE_EN
  logic [3:0]  ram_w_strb_i = 4'hF;
`endif
  logic        ld_start_i = 1'b0;
  logic        ld_valid_i = 1'b0;
  logic [7:0]  ld_data_i  = '0;
  logic        ld_last_i  = 1'b0;
  logic        ld_ready_o;
  logic        ld_ovf_o;
  logic        ram_err_o;

  int total = 0;
  int bad   = 0;

  soc_mem_subsys #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .ROM_WORDS (4),
    .RAM_WORDS (16),
    .RAM_BANKS (2)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .hold_i       (hold_i),
    .hold_o       (hold_o),
    .rom_r_addr_i (rom_r_addr_i),
    .rom_r_data_o (rom_r_data_o),
    .ram_r_ena_i  (ram_r_ena_i),
    .ram_r_addr_i (ram_r_addr_i),
    .ram_r_data_o (ram_r_data_o),
    .ram_w_ena_i  (ram_w_ena_i),
    .ram_w_addr_i (ram_w_addr_i),
    .ram_w_data_i (ram_w_data_i),
`ifdef SOC_MEM_BYTE_WE_EN
    .ram_w_strb_i (ram_w_strb_i),
`endif
    .ld_start_i   (ld_start_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_last_i    (ld_last_i),
    .ld_ready_o   (ld_ready_o),
    .ld_ovf_o     (ld_ovf_o),
    .ram_err_o    (ram_err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("ok   %s obs=%h exp=%h", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    ld_last_i  = last;
    step();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
  endtask

  task automatic rom_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rom_r_addr_i = addr;
    #1;
    check(tag, rom_r_data_o, exp);
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
    ram_w_ena_i  = 1'b1;
    ram_w_addr_i = addr;
    ram_w_data_i = data;
    step();
    ram_w_ena_i  = 1'b0;
  endtask

  task automatic ram_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ram_r_ena_i  = 1'b1;
    ram_r_addr_i = addr;
    #1;
    check(tag, ram_r_data_o, exp);
    ram_r_ena_i  = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_hold",  {31'd0, hold_o},     32'd1);
    check("rst_ready", {31'd0, ld_ready_o}, 32'd1);
    check("rst_ovf",   {31'd0, ld_ovf_o},   32'd0);
    check("rst_err",   {31'd0, ram_err_o},  32'd0);
    arst_n = 1'b1;
    step();

    // Image 00..07, last on byte 7
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    check("t1_flush_hold",  {31'd0, hold_o},     32'd1);
    check("t1_flush_ready", {31'd0, ld_ready_o}, 32'd0);
    step();
    check("t1_run_hold",    {31'd0, hold_o},     32'd0);
    rom_read("t1_rom0", 32'h0, 32'h03020100);
    rom_read("t1_rom1", 32'h4, 32'h07060504);
    rom_read("t1_rom_oob", 32'h10, 32'h0);
    hold_i = 1'b1;
    #1;
    check("t1_hold_pass", {31'd0, hold_o}, 32'd1);
    hold_i = 1'b0;
    step();

    // Restart from RUN, image AA..EE with partial final word
    pulse_start();
    check("t2_start_hold",  {31'd0, hold_o},     32'd1);
    check("t2_start_ready", {31'd0, ld_ready_o}, 32'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    check("t2_flush_ready", {31'd0, ld_ready_o}, 32'd0);
    check("t2_flush_hold",  {31'd0, hold_o},     32'd1);
    step();
    check("t2_run_hold",    {31'd0, hold_o},     32'd0);
    rom_read("t2_rom0", 32'h0, 32'hDDCCBBAA);
    rom_read("t2_rom1", 32'h4, 32'h000000EE);
    step();

    // Overflow: 20 bytes into a 4-word ROM
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    check("t3_full_ovf",   {31'd0, ld_ovf_o},   32'd0);
    check("t3_full_ready", {31'd0, ld_ready_o}, 32'd1);
    send_byte(8'h20, 1'b0);
    check("t3_ovf_set",    {31'd0, ld_ovf_o},   32'd1);
    check("t3_ovf_ready",  {31'd0, ld_ready_o}, 32'd1);
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b1);
    step();
    check("t3_run_hold",   {31'd0, hold_o},     32'd0);
    check("t3_run_ovf",    {31'd0, ld_ovf_o},   32'd1);
    rom_read("t3_rom0_nowrap", 32'h0, 32'h13121110);
    rom_read("t3_rom3", 32'hC, 32'h1F1E1D1C);
    step();

    // Restart clears overflow; a start during LOAD drops its byte
    pulse_start();
    check("t4_start_hold", {31'd0, hold_o},   32'd1);
    check("t4_ovf_clr",    {31'd0, ld_ovf_o}, 32'd0);
    send_byte(8'h55, 1'b0);
    ld_start_i = 1'b1;
    send_byte(8'h99, 1'b0);
    ld_start_i = 1'b0;
    send_byte(8'h44, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'h46, 1'b0);
    send_byte(8'h47, 1'b1);
    step();
    check("t4_run_hold", {31'd0, hold_o}, 32'd0);
    rom_read("t4_rom0", 32'h0, 32'h47464544);
    rom_read("t4_rom1", 32'h4, 32'h17161514);
    step();

    // Banked RAM write/read in RUN
    ram_write(32'h0, 32'h11112222);
    ram_write(32'h4, 32'h12345678);
    ram_write(32'h8, 32'h9ABCDEF0);
    ram_read("t5_ram4", 32'h4, 32'h12345678);
    ram_read("t5_ram8", 32'h8, 32'h9ABCDEF0);
    ram_read("t5_ram0", 32'h0, 32'h11112222);
    ram_r_addr_i = 32'h4;
    #1;
    check("t5_rd_disabled", ram_r_data_o, 32'h0);
    check("t5_err_clean", {31'd0, ram_err_o}, 32'd0);
    step();

    // Same-address read and write in one cycle
    ram_r_ena_i  = 1'b1;
    ram_r_addr_i = 32'h4;
    ram_w_ena_i  = 1'b1;
    ram_w_addr_i = 32'h4;
    ram_w_data_i = 32'hCAFEF00D;
    #1;
    check("t5_rw_old", ram_r_data_o, 32'h12345678);
    step();
    ram_w_ena_i = 1'b0;
    #1;
    check("t5_rw_new", ram_r_data_o, 32'hCAFEF00D);
    ram_r_ena_i = 1'b0;
    step();

    // Out-of-range write dropped and flagged
    ram_write(32'd64, 32'hDEADBEEF);
    check("t5_oob_err", {31'd0, ram_err_o}, 32'd1);
    ram_read("t5_oob_nowrap", 32'h0, 32'h11112222);
    ram_read("t5_oob_read", 32'd64, 32'h0);
    step();

`ifdef SOC_MEM_BYTE_WE_EN
    // Byte strobes: only lane 1 written, then an all-zero strobe
    ram_w_strb_i = 4'b0010;
    ram_write(32'h8, 32'hFFFFFFFF);
    ram_read("t6_strb_lane1", 32'h8, 32'h9ABCFFF0);
    ram_w_strb_i = 4'b0000;
    ram_write(32'h8, 32'h00000000);
    ram_read("t6_strb_none", 32'h8, 32'h9ABCFFF0);
    ram_w_strb_i = 4'hF;
    step();
`endif

    // Reset again, then an out-of-range read alone sets the error flag
    arst_n = 1'b0;
    #1;
    check("t7_rst_err",   {31'd0, ram_err_o},  32'd0);
    check("t7_rst_hold",  {31'd0, hold_o},     32'd1);
    check("t7_rst_ready", {31'd0, ld_ready_o}, 32'd1);
    step();
    arst_n = 1'b1;
    step();
    ram_r_ena_i  = 1'b1;
    ram_r_addr_i = 32'd80;
    step();
    ram_r_ena_i  = 1'b0;
    check("t7_rd_oob_err", {31'd0, ram_err_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
